elevator_ctrl: RTL
==================

# elevator_ctrl

N-floor elevator controller, successor to the two-floor elevator state machine. Latches one-shot floor requests from the button debouncers and serves them with a SCAN (continue-in-direction) policy. Generates per-floor travel timing and door dwell internally from a shared `tick` strobe, and reports state, current floor and pending requests to the display/LED logic.

## Interface
- `NUM_FLOORS`, 4: number of floors, 2..16.
- `TRAVEL_TICKS`, 5: ticks to travel one floor, ≥1.
- `DOOR_TICKS`, 3: ticks the door stays open, ≥1.
- Derived: `FW = max(1, $clog2(NUM_FLOORS))`; `CW = $clog2(max(TRAVEL_TICKS, DOOR_TICKS) + 1)`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle timebase strobe (1 Hz in system).
- `btn_stable_shot` in NUM_FLOORS: one-cycle request pulses, bit i = floor i.
- `state` out 3: FSM state code.
- `cur_floor` out FW: floor the car is at, or the last floor passed.
- `req_pending` out NUM_FLOORS: latched, unserved requests.
- `counting_value` out CW: remaining ticks of the current travel or dwell.
- `door_open` out 1: high in DOOR_OPEN.
- `dir_up` out 1: current or last travel direction, 1 = up.

## Operation
- State codes:
  - IDLE = 0
  - MOVE_UP = 1
  - MOVE_DOWN = 2
  - DOOR_OPEN = 3
  - HALT = 4 (macro only)
  - Codes 5–7 return to IDLE.
- Request latch: `btn_stable_shot[i]` sets `req_pending[i]` on the next edge.
- Suppressed requests:
  - A pulse for `cur_floor` in IDLE is not latched. It sends the FSM to DOOR_OPEN instead.
  - A pulse for `cur_floor` in DOOR_OPEN is not latched. It reloads `counting_value` to DOOR_TICKS.
- `above` = any pending bit > `cur_floor`; `below` = any pending bit < `cur_floor`.
- IDLE:
  - If `dir_up` and `above`, go to MOVE_UP. Else if `below`, go to MOVE_DOWN. Else if `above`, go to MOVE_UP.
  - On entry to a MOVE state, `counting_value` = TRAVEL_TICKS and `dir_up` updates.
- MOVE_x:
  - Each `tick` decrements `counting_value`.
  - On the tick where `counting_value` == 1, `cur_floor` moves ±1.
  - If the new floor is pending: clear its bit, go to DOOR_OPEN, `counting_value` = DOOR_TICKS.
  - Otherwise reload TRAVEL_TICKS and continue.
- DOOR_OPEN:
  - Each `tick` decrements `counting_value`.
  - On expiry: continue in `dir_up` direction if requests lie ahead. Else reverse if requests lie behind. Else go to IDLE.
- Moving off the top floor or below floor 0 is impossible by construction; the bench asserts it never happens.
- A request for `cur_floor` during a MOVE state is latched. It is served after the car reverses.

## Timing
- Reset values: `state` = IDLE, `cur_floor` = 0, `req_pending` = 0, `counting_value` = 0, `door_open` = 0, `dir_up` = 1.
- State, floor and counter change only on `clk` edges.
- Timer values advance only on cycles with `tick` = 1.
- Request-to-latch latency: 1 cycle.
- IDLE with a pending request reaches a MOVE state 1 cycle later, independent of `tick`.
- Total travel time = TRAVEL_TICKS × floors ticks. Door dwell = DOOR_TICKS ticks.
- Simultaneous set and clear of the same bit on arrival: clear wins and the request counts as served.
- `btn_stable_shot` with multiple bits set in one cycle: all bits latch.
- Reset assertion mid-travel returns every output to its reset value immediately.

## Configuration
- `ELEVATOR_ESTOP_EN` defined:
  - Adds input `estop` (1 bit, active-high).
  - While `estop` is high, `state` = HALT, `counting_value` freezes and `door_open` = 0. Requests still latch.
  - On release, the FSM returns to the saved pre-HALT state with the counter intact.
- `ELEVATOR_ESTOP_EN` undefined: no `estop` port, HALT unreachable, code 4 behaves as an illegal code.

## Structure
- Package `elevator_pkg` holds:
  - State code localparams.
  - FW and CW width functions.
- Sub-module `elevator_req_scan` (combinational): computes `above`, `below` and `hit_cur` from `req_pending`, `cur_floor` and `btn_stable_shot`.
- The FSM and timer live in `elevator_ctrl`.

## Test plan
All scenarios use NUM_FLOORS=4, TRAVEL_TICKS=5, DOOR_TICKS=3, `tick` every cycle.
- Reset, then pulse floor 2 → MOVE_UP. `cur_floor` = 1 after 5 ticks, 2 after 10 ticks. DOOR_OPEN for 3 ticks, then IDLE. `req_pending` = 0.
- At floor 0 in IDLE, pulse floor 0 → DOOR_OPEN 1 cycle later. `req_pending` stays 0.
- Moving up from 0 with floors 3 and 1 pending → stops at 1 then 3 (DOOR_OPEN each), then IDLE at floor 3.
- At floor 2 in DOOR_OPEN with `dir_up` = 1, floors 0 and 3 pending → serves 3 first, then reverses to 0.
- Reset asserted at `counting_value` = 2 mid-travel → all outputs at reset values while `rst` is low.
- With `ELEVATOR_ESTOP_EN`: `estop` high for 7 cycles at `counting_value` = 3 → HALT, counter stays 3. On release, resumes MOVE_UP and arrives 3 ticks later.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: state codes and width helpers for elevator_ctrl.
// Shared by the interface, the request scanner and the controller.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MOVE_UP   = 3'd1;
  localparam logic [2:0] MOVE_DOWN = 3'd2;
  localparam logic [2:0] DOOR_OPEN = 3'd3;
  localparam logic [2:0] HALT      = 3'd4;

  function automatic int fw_of(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cw_of(int t, int d);
    int m;
    m = (t > d) ? t : d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/elevator_if.sv
// elevator_if: controller <-> panel/display bundle.
// master drives tick and request pulses; slave (controller) drives status.
interface elevator_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FW = 2,
  parameter int CW = 3
);
  logic                  tick;
  logic [NUM_FLOORS-1:0] btn_stable_shot;
  logic [2:0]            state;
  logic [FW-1:0]         cur_floor;
  logic [NUM_FLOORS-1:0] req_pending;
  logic [CW-1:0]         counting_value;
  logic                  door_open;
  logic                  dir_up;

  modport master (
    output tick, btn_stable_shot,
    input  state, cur_floor, req_pending,
    input  counting_value, door_open, dir_up
  );

  modport slave (
    input  tick, btn_stable_shot,
    output state, cur_floor, req_pending,
    output counting_value, door_open, dir_up
  );
endinterface

// File: rtl/elevator_req_scan.sv
// elevator_req_scan: combinational request scan relative to the car.
// Ports: i_req, i_floor, i_shot in; o_above, o_below, o_hit_cur out.
import elevator_pkg::*;

module elevator_req_scan #(
  parameter int NUM_FLOORS = 4,
  parameter int FW = 2
) (
  input  logic [NUM_FLOORS-1:0] i_req,
  input  logic [FW-1:0]         i_floor,
  input  logic [NUM_FLOORS-1:0] i_shot,
  output logic                  o_above,
  output logic                  o_below,
  output logic                  o_hit_cur
);

  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_req[i] && (i > int'(i_floor))) o_above = 1'b1;
      if (i_req[i] && (i < int'(i_floor))) o_below = 1'b1;
    end
  end

  assign o_hit_cur = |(i_shot & (NUM_FLOORS'(1) << i_floor));

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: N-floor SCAN elevator FSM with tick-based travel/dwell timer.
// Ports: clk, rst (async active-low), bus (elevator_if.slave);
// estop (active-high) exists only when ELEVATOR_ESTOP_EN is defined.
import elevator_pkg::*;

module elevator_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int TRAVEL_TICKS = 5,
  parameter int DOOR_TICKS   = 3
) (
  input  logic clk,
  input  logic rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic estop,
`endif
  elevator_if.slave bus
);

  localparam int FW = fw_of(NUM_FLOORS);
  localparam int CW = cw_of(TRAVEL_TICKS, DOOR_TICKS);
  localparam logic [CW-1:0] C_TRAV = CW'(TRAVEL_TICKS);
  localparam logic [CW-1:0] C_DOOR = CW'(DOOR_TICKS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [FW-1:0] F_ONE  = FW'(1);

  state_t                r_state, w_state_n;
  logic [FW-1:0]         r_floor, w_floor_n;
  logic [NUM_FLOORS-1:0] r_req, w_req_n;
  logic [NUM_FLOORS-1:0] w_set, w_clr;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic                  r_dir, w_dir_n;

  logic                  w_above, w_below, w_hit;
  logic                  w_ahead, w_behind;
  logic                  w_estop;
  logic [FW-1:0]         w_nf;
  logic [NUM_FLOORS-1:0] w_nf_mask, w_cur_mask;
  logic                  w_nf_pend;

`ifdef ELEVATOR_ESTOP_EN
  state_t r_saved;
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  elevator_req_scan #(
    .NUM_FLOORS(NUM_FLOORS),
    .FW(FW)
  ) u_scan (
    .i_req(r_req),
    .i_floor(r_floor),
    .i_shot(bus.btn_stable_shot),
    .o_above(w_above),
    .o_below(w_below),
    .o_hit_cur(w_hit)
  );

  assign w_ahead  = r_dir ? w_above : w_below;
  assign w_behind = r_dir ? w_below : w_above;

  // Floor the car reaches when the current leg finishes.
  assign w_nf = (r_state == ST_MOVE_UP) ? r_floor + F_ONE
                                        : r_floor - F_ONE;
  assign w_nf_mask  = NUM_FLOORS'(1) << w_nf;
  assign w_cur_mask = NUM_FLOORS'(1) << r_floor;
  // A pulse on the arrival edge counts as served.
  assign w_nf_pend  = |((r_req | bus.btn_stable_shot) & w_nf_mask);

  always_comb begin
    w_state_n = r_state;
    w_floor_n = r_floor;
    w_cnt_n   = r_cnt;
    w_dir_n   = r_dir;
    w_set     = bus.btn_stable_shot;
    w_clr     = '0;
    if (w_estop) begin
      w_state_n = ST_HALT;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_set = bus.btn_stable_shot & ~w_cur_mask;
          if (w_hit) begin
            w_state_n = ST_DOOR_OPEN;
            w_cnt_n   = C_DOOR;
          end else if (r_dir && w_above) begin
            w_state_n = ST_MOVE_UP;
            w_cnt_n   = C_TRAV;
          end else if (w_below) begin
            w_state_n = ST_MOVE_DOWN;
            w_cnt_n   = C_TRAV;
            w_dir_n   = 1'b0;
          end else if (w_above) begin
            w_state_n = ST_MOVE_UP;
            w_cnt_n   = C_TRAV;
            w_dir_n   = 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (bus.tick) begin
            if (r_cnt <= C_ONE) begin
              w_floor_n = w_nf;
              if (w_nf_pend) begin
                w_clr     = w_nf_mask;
                w_state_n = ST_DOOR_OPEN;
                w_cnt_n   = C_DOOR;
              end else begin
                w_cnt_n = C_TRAV;
              end
            end else begin
              w_cnt_n = r_cnt - C_ONE;
            end
          end
        end
        ST_DOOR_OPEN: begin
          w_set = bus.btn_stable_shot & ~w_cur_mask;
          if (w_hit) begin
            w_cnt_n = C_DOOR;
          end else if (bus.tick) begin
            if (r_cnt <= C_ONE) begin
              if (w_ahead) begin
                w_state_n = r_dir ? ST_MOVE_UP : ST_MOVE_DOWN;
                w_cnt_n   = C_TRAV;
              end else if (w_behind) begin
                w_state_n = r_dir ? ST_MOVE_DOWN : ST_MOVE_UP;
                w_dir_n   = ~r_dir;
                w_cnt_n   = C_TRAV;
              end else begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
              end
            end else begin
              w_cnt_n = r_cnt - C_ONE;
            end
          end
        end
`ifdef ELEVATOR_ESTOP_EN
        ST_HALT: begin
          // Resume exactly where the stop found us; counter untouched.
          w_state_n = r_saved;
        end
`endif
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
    w_req_n = (r_req | w_set) & ~w_clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_floor <= '0;
      r_req   <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_floor <= w_floor_n;
      r_req   <= w_req_n;
      r_cnt   <= w_cnt_n;
      r_dir   <= w_dir_n;
    end
  end

`ifdef ELEVATOR_ESTOP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_saved <= ST_IDLE;
    end else if (w_estop && (r_state != ST_HALT)) begin
      r_saved <= r_state;
    end
  end
`endif

  assign bus.state          = r_state;
  assign bus.cur_floor      = r_floor;
  assign bus.req_pending    = r_req;
  assign bus.counting_value = r_cnt;
  assign bus.door_open      = (r_state == ST_DOOR_OPEN);
  assign bus.dir_up         = r_dir;

endmodule
